// File: rtl/bpu_pkg.sv
// bpu_pkg: shared types and sizing helpers for the branch predictor.
// BTB entry layout, table geometry and invalidate-sweep FSM encoding.
package bpu_pkg;

  // Widest PC the entry fields hold; narrower PCs zero-extend into it.
  localparam int BTB_AW = 32;

  typedef struct packed {
    logic              valid;
    logic [BTB_AW-1:0] tag;
    logic [BTB_AW-1:0] target;
    logic              uncond;
  } btb_entry_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } sweep_st_t;

  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_w(input int pc_w, input int entries);
    return pc_w - $clog2(entries) - 2;
  endfunction

  // Weakly-not-taken: MSB clear, all lower bits set.
  function automatic int ctr_wnt(input int cnt_w);
    return (1 << (cnt_w - 1)) - 1;
  endfunction

  localparam int CTR_WNT = ctr_wnt(2);

endpackage

// File: rtl/sat_counter.sv
// sat_counter: next-value logic for a saturating up/down counter.
// Load has priority; inc and dec together hold the value.
module sat_counter #(
  parameter int W = 2
) (
  input  logic [W-1:0] cnt_i,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o
);

  // Step toward the rails, sticking at all-ones and zero.
  always_comb begin
    cnt_o = cnt_i;
    if (load_i) begin
      cnt_o = load_val_i;
    end else if (inc_i && !dec_i && (cnt_i != '1)) begin
      cnt_o = cnt_i + W'(1);
    end else if (dec_i && !inc_i && (cnt_i != '0)) begin
      cnt_o = cnt_i - W'(1);
    end
  end

endmodule

// File: rtl/bpu_btb.sv
// bpu_btb: direct-mapped BTB plus PHT with optional gshare history.
// IF looks up combinationally; ID trains; a sweep FSM invalidates all.
module bpu_btb
  import bpu_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32,
  parameter int CNT_W   = 2,
  parameter int GHR_W   = 0,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   lk_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic              upd_uncond,
  input  logic              upd_taken,
  input  logic [PC_W-1:0]   upd_target,
  input  logic              upd_pred_taken,
  input  logic [PC_W-1:0]   upd_pred_target,
  output logic              upd_mispredict,
  input  logic              inv_req,
  output logic              busy,
  output logic [PERF_W-1:0] perf_br,
  output logic [PERF_W-1:0] perf_miss
);

  localparam int IDX_W = idx_w(ENTRIES);
  localparam int TAG_W = tag_w(PC_W, ENTRIES);
  localparam logic [CNT_W-1:0] WNT = CNT_W'(ctr_wnt(CNT_W));
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);

  btb_entry_t       btb_q [ENTRIES];
  logic [CNT_W-1:0] pht_q [ENTRIES];

  sweep_st_t        st_q, st_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [PERF_W-1:0] br_q, br_d;
  logic [PERF_W-1:0] miss_q, miss_d;

  logic [IDX_W-1:0] ghr_ext;
  logic [IDX_W-1:0] lk_bi, lk_pi;
  logic [IDX_W-1:0] up_bi, up_pi;
  logic [TAG_W-1:0] lk_tag, up_tag;

  btb_entry_t       lk_e;
  btb_entry_t       wr_e;
  logic [CNT_W-1:0] pht_cur;
  logic [CNT_W-1:0] pht_nxt;

  logic sweep_go;
  logic acc;
  logic unused_pc_lsb;

  assign unused_pc_lsb = ^upd_pc[1:0];

  assign lk_bi  = lk_pc[IDX_W+1:2];
  assign lk_tag = lk_pc[PC_W-1:IDX_W+2];
  assign up_bi  = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[PC_W-1:IDX_W+2];

  assign lk_pi = lk_bi ^ ghr_ext;
  assign up_pi = up_bi ^ ghr_ext;

  assign busy     = (st_q == ST_CLEAR);
  assign sweep_go = (st_q == ST_IDLE) && inv_req;
  assign acc      = upd_valid && !busy && !inv_req;

  assign lk_e = btb_q[lk_bi];

  assign pred_hit   = lk_e.valid
                   && (lk_e.tag == BTB_AW'(lk_tag))
                   && !busy;
  assign pred_taken = pred_hit
                   && (lk_e.uncond || pht_q[lk_pi][CNT_W-1]);
  assign pred_target = pred_taken ? lk_e.target[PC_W-1:0]
                                  : lk_pc + PC_W'(4);

  assign upd_mispredict = upd_valid
    && ((upd_taken != upd_pred_taken)
     || (upd_taken && (upd_target != upd_pred_target)));

  // Global history: shifted by accepted conditional outcomes.
  generate
    if (GHR_W > 0) begin : g_ghr
      logic [GHR_W-1:0] ghr_q, ghr_d;

      assign ghr_ext = IDX_W'(ghr_q);

      // Clear on sweep start, else shift in the resolved outcome.
      always_comb begin
        ghr_d = ghr_q;
        if (sweep_go) begin
          ghr_d = '0;
        end else if (acc && !upd_uncond) begin
          ghr_d = (ghr_q << 1) | GHR_W'(upd_taken);
        end
      end

      // History register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ghr_q <= '0;
        end else begin
          ghr_q <= ghr_d;
        end
      end
    end else begin : g_bimodal
      assign ghr_ext = '0;
    end
  endgenerate

  assign pht_cur = pht_q[up_pi];

  sat_counter #(.W(CNT_W)) u_pht_ctr (
    .cnt_i      (pht_cur),
    .inc_i      (upd_taken),
    .dec_i      (!upd_taken),
    .load_i     (1'b0),
    .load_val_i (WNT),
    .cnt_o      (pht_nxt)
  );

  sat_counter #(.W(PERF_W)) u_perf_br (
    .cnt_i      (br_q),
    .inc_i      (acc),
    .dec_i      (1'b0),
    .load_i     (1'b0),
    .load_val_i ('0),
    .cnt_o      (br_d)
  );

  sat_counter #(.W(PERF_W)) u_perf_miss (
    .cnt_i      (miss_q),
    .inc_i      (acc && upd_mispredict),
    .dec_i      (1'b0),
    .load_i     (1'b0),
    .load_val_i ('0),
    .cnt_o      (miss_d)
  );

  assign perf_br   = br_q;
  assign perf_miss = miss_q;

  // Entry written on every accepted taken outcome.
  always_comb begin
    wr_e        = '0;
    wr_e.valid  = 1'b1;
    wr_e.tag    = BTB_AW'(up_tag);
    wr_e.target = BTB_AW'(upd_target);
    wr_e.uncond = upd_uncond;
  end

  // Sweep sequencing: walk every index once, then return to idle.
  always_comb begin
    st_d  = st_q;
    idx_d = idx_q;
    unique case (st_q)
      ST_IDLE: begin
        if (inv_req) begin
          st_d  = ST_CLEAR;
          idx_d = '0;
        end
      end
      ST_CLEAR: begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST) begin
          st_d = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // Sweep state and index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= ST_IDLE;
      idx_q <= '0;
    end else begin
      st_q  <= st_d;
      idx_q <= idx_d;
    end
  end

  // BTB array: sweep clears valid, taken updates fill an entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '0;
      end
    end else if (busy) begin
      btb_q[idx_q].valid <= 1'b0;
    end else if (acc && upd_taken) begin
      btb_q[up_bi] <= wr_e;
    end
  end

  // PHT array: sweep reloads weakly-not-taken, branches train.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht_q[i] <= WNT;
      end
    end else if (busy) begin
      pht_q[idx_q] <= WNT;
    end else if (acc && !upd_uncond) begin
      pht_q[up_pi] <= pht_nxt;
    end
  end

  // Performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_q   <= '0;
      miss_q <= '0;
    end else begin
      br_q   <= br_d;
      miss_q <= miss_d;
    end
  end

endmodule
